// File: rtl/tlb_responder_if.sv
// rtl/tlb_responder_if.sv - translation request/response and page-table read bundle
interface tlb_responder_if #(
    parameter int PA_W = 12
);
    logic            req_valid;
    logic            req_ready;
    logic [15:0]     req_vaddr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [PA_W-1:0] rsp_paddr;
    logic            rsp_fault;
    logic            mem_req;
    logic [15:0]     mem_addr;
    logic            mem_ack;
    logic [15:0]     mem_rdata;

    modport master (
        output req_valid, req_vaddr, rsp_ready, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_paddr, rsp_fault, mem_req, mem_addr
    );

    modport slave (
        input  req_valid, req_vaddr, rsp_ready, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_paddr, rsp_fault, mem_req, mem_addr
    );
endinterface

// File: rtl/tlb_responder.sv
// rtl/tlb_responder.sv - fully-associative TLB with single-level page-table walk
// Optional hit/miss counters are built when TLB_STATS_EN is defined.
module tlb_responder #(
    parameter int          ENTRIES = 4,
    parameter int          OFF_W   = 6,
    parameter int          PPN_W   = 6,
    parameter logic [15:0] PT_BASE = 16'h0F00
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic           flush,
    tlb_responder_if.slave bus
`ifdef TLB_STATS_EN
    ,
    output logic [15:0]    hit_cnt,
    output logic [15:0]    miss_cnt
`endif
);
    localparam int VPN_W = 16 - OFF_W;
    localparam int PA_W  = PPN_W + OFF_W;
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_HIT,
        S_WALK,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [15:0]         vaddr_q;
    logic [ENTRIES-1:0]  valid_q;
    logic [VPN_W-1:0]    vpn_q [ENTRIES];
    logic [PPN_W-1:0]    ppn_q [ENTRIES];
    logic [IDX_W-1:0]    rr_q;
    logic                walk_flush_q;

    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [PA_W-1:0]     rsp_paddr_q;
    logic                rsp_fault_q;
    logic                mem_req_q;
    logic [15:0]         mem_addr_q;

    logic [VPN_W-1:0]    cur_vpn;
    logic [OFF_W-1:0]    cur_off;
    logic [PPN_W-1:0]    pte_ppn;
    logic                pte_valid;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                has_free;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    victim;
    logic                unused_pte_bits;

    assign cur_vpn         = vaddr_q[15:OFF_W];
    assign cur_off         = vaddr_q[OFF_W-1:0];
    assign pte_valid       = bus.mem_rdata[15];
    assign pte_ppn         = bus.mem_rdata[PPN_W-1:0];
    assign unused_pte_bits = ^bus.mem_rdata[14:PPN_W];

    // Hit search plus victim choice: lowest free slot first, round-robin only when full.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (vpn_q[i] == cur_vpn) && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        victim = has_free ? free_idx : rr_q;
    end

`ifdef TLB_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            state_q      <= S_IDLE;
            vaddr_q      <= '0;
            valid_q      <= '0;
            rr_q         <= '0;
            walk_flush_q <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_paddr_q  <= '0;
            rsp_fault_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
`ifdef TLB_STATS_EN
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
`endif
        end else begin
            if (flush) begin
                valid_q <= '0;
                rr_q    <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        vaddr_q     <= bus.req_vaddr;
                        req_ready_q <= 1'b0;
                        state_q     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        rsp_paddr_q <= {ppn_q[hit_idx], cur_off};
                        rsp_fault_q <= 1'b0;
                        state_q     <= S_HIT;
`ifdef TLB_STATS_EN
                        hit_cnt_q   <= hit_cnt_q + 16'd1;
`endif
                    end else begin
                        mem_req_q    <= 1'b1;
                        mem_addr_q   <= PT_BASE + 16'(cur_vpn);
                        walk_flush_q <= 1'b0;
                        state_q      <= S_WALK;
`ifdef TLB_STATS_EN
                        miss_cnt_q   <= miss_cnt_q + 16'd1;
`endif
                    end
                end
                S_HIT: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_WALK: begin
                    if (bus.mem_ack) begin
                        mem_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                        if (pte_valid) begin
                            rsp_paddr_q <= {pte_ppn, cur_off};
                            rsp_fault_q <= 1'b0;
                            // Any flush seen during the walk (including this edge) cancels the fill.
                            if (!flush && !walk_flush_q) begin
                                valid_q[victim] <= 1'b1;
                                vpn_q[victim]   <= cur_vpn;
                                ppn_q[victim]   <= pte_ppn;
                                if (!has_free) begin
                                    rr_q <= rr_q + 1'b1;
                                end
                            end
                        end else begin
                            rsp_paddr_q <= '0;
                            rsp_fault_q <= 1'b1;
                        end
                    end else if (flush) begin
                        walk_flush_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_paddr = rsp_paddr_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_tlb_responder.sv
// tb/tb_tlb_responder.sv - vector table plus randomized model-checked bench for tlb_responder
module tb_tlb_responder;
    localparam int NE = 4;

    logic Clock;
    logic Resetn;
    logic flush;
    int   n_tests;
    int   n_fail;

    tlb_responder_if #(.PA_W(12)) bus();

`ifdef TLB_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    tlb_responder #(
        .ENTRIES(NE),
        .OFF_W  (6),
        .PPN_W  (6),
        .PT_BASE(16'h0F00)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .flush (flush),
        .bus   (bus)
`ifdef TLB_STATS_EN
        ,
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] va;
        logic [15:0] pte;
        int          dly;
        bit          pre_fl;
        bit          fll;
        bit          flw;
        int          hold;
        bit          miss;
        logic [15:0] maddr;
        logic [11:0] pa;
        bit          fault;
    } vec_t;

    // Reference TLB: plain arrays and a round-robin integer.
    bit m_v[NE];
    int m_vpn[NE];
    int m_ppn[NE];
    int m_rr;
    int m_hits;
    int m_misses;

    function automatic void m_clear();
        for (int i = 0; i < NE; i++) m_v[i] = 1'b0;
        m_rr = 0;
    endfunction

    function automatic void m_fill(input int vpn, input int ppn);
        int idx = -1;
        for (int i = 0; i < NE; i++) if (!m_v[i] && idx < 0) idx = i;
        if (idx < 0) begin
            idx  = m_rr;
            m_rr = (m_rr + 1) % NE;
        end
        m_v[idx]   = 1'b1;
        m_vpn[idx] = vpn;
        m_ppn[idx] = ppn;
    endfunction

    function automatic void m_predict(inout vec_t v);
        int vpn = int'(v.va) / 64;
        int off = int'(v.va) % 64;
        int hit = -1;
        if (v.pre_fl) m_clear();
        for (int i = 0; i < NE; i++) if (m_v[i] && m_vpn[i] == vpn) hit = i;
        if (hit >= 0) begin
            v.miss  = 1'b0;
            v.maddr = 16'h0;
            v.pa    = 12'(m_ppn[hit] * 64 + off);
            v.fault = 1'b0;
            m_hits++;
            if (v.fll) m_clear();
        end else begin
            m_misses++;
            v.miss  = 1'b1;
            v.maddr = 16'((32'h0F00 + vpn) % 65536);
            if (v.fll) m_clear();
            if (v.pte[15]) begin
                v.pa    = 12'((int'(v.pte) % 64) * 64 + off);
                v.fault = 1'b0;
                if (v.flw) m_clear();
                else m_fill(vpn, int'(v.pte) % 64);
            end else begin
                v.pa    = 12'h0;
                v.fault = 1'b1;
                if (v.flw) m_clear();
            end
        end
    endfunction

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] pte, input int dly,
                                input bit pre_fl, input bit fll, input bit flw, input int hold,
                                input bit miss, input logic [15:0] maddr, input logic [11:0] pa,
                                input bit fault);
        vec_t v;
        v.va = va; v.pte = pte; v.dly = dly; v.pre_fl = pre_fl; v.fll = fll; v.flw = flw;
        v.hold = hold; v.miss = miss; v.maddr = maddr; v.pa = pa; v.fault = fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int edges;
        int walk_cyc;
        bit seen_mem;
        if (v.pre_fl) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        chk({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_vaddr = v.va;
        step();
        bus.req_valid = 1'b0;
        edges    = 0;
        walk_cyc = 0;
        seen_mem = 1'b0;
        while (edges < 60 && !bus.rsp_valid) begin
            flush = v.fll && (edges == 0);
            if (bus.mem_req) begin
                seen_mem = 1'b1;
                if (walk_cyc == 0 || walk_cyc == v.dly)
                    chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(v.maddr));
                if (v.flw && walk_cyc == 0) flush = 1'b1;
                if (walk_cyc == v.dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = v.pte;
                end
                walk_cyc++;
            end
            step();
            edges++;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 16'($urandom);
            flush         = 1'b0;
        end
        chk({tag, " latency"}, 32'(edges), 32'(v.miss ? 2 + v.dly : 2));
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, " walked"}, 32'(seen_mem), 32'(v.miss));
        chk({tag, " rsp_paddr"}, 32'(bus.rsp_paddr), 32'(v.pa));
        chk({tag, " rsp_fault"}, 32'(bus.rsp_fault), 32'(v.fault));
        // Backpressure: stray requests and acks must not disturb the held response.
        for (int h = 0; h < v.hold; h++) begin
            bus.req_valid = 1'b1;
            bus.req_vaddr = 16'($urandom);
            bus.mem_ack   = 1'($urandom);
            step();
            chk({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, " hold rsp_paddr"}, 32'(bus.rsp_paddr), 32'(v.pa));
            chk({tag, " hold rsp_fault"}, 32'(bus.rsp_fault), 32'(v.fault));
            chk({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk({tag, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " req_ready back"}, 32'(bus.req_ready), 32'd1);
    endtask

    vec_t        tbl[$];
    vec_t        mv;
    logic [15:0] pt[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_clear();
        m_hits = 0;
        m_misses = 0;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_vaddr = 16'h0;
        bus.rsp_ready = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0;
        Resetn = 1'b1;
        step();
        step();
        Resetn = 1'b0;
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_paddr", 32'(bus.rsp_paddr), 32'd0);
        chk("reset rsp_fault", 32'(bus.rsp_fault), 32'd0);
        chk("reset mem_req", 32'(bus.mem_req), 32'd0);
        chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);

        //                va        pte       dly pf fl fw hold miss maddr     pa       fault
        tbl.push_back(mk(16'h0085, 16'h8003, 3, 0, 0, 0, 0, 1, 16'h0F02, 12'h0C5, 0));
        tbl.push_back(mk(16'h0087, 16'h0000, 1, 0, 0, 0, 4, 0, 16'h0000, 12'h0C7, 0));
        tbl.push_back(mk(16'h0100, 16'h0003, 1, 0, 0, 0, 4, 1, 16'h0F04, 12'h000, 1));
        tbl.push_back(mk(16'h0100, 16'h0003, 2, 0, 0, 0, 0, 1, 16'h0F04, 12'h000, 1));
        tbl.push_back(mk(16'h0086, 16'h8003, 1, 1, 0, 0, 0, 1, 16'h0F02, 12'h0C6, 0));
        tbl.push_back(mk(16'h0041, 16'h8011, 1, 1, 0, 0, 0, 1, 16'h0F01, 12'h441, 0));
        tbl.push_back(mk(16'h0082, 16'h8012, 1, 0, 0, 0, 0, 1, 16'h0F02, 12'h482, 0));
        tbl.push_back(mk(16'h00C3, 16'h8013, 1, 0, 0, 0, 0, 1, 16'h0F03, 12'h4C3, 0));
        tbl.push_back(mk(16'h0104, 16'h8014, 1, 0, 0, 0, 0, 1, 16'h0F04, 12'h504, 0));
        tbl.push_back(mk(16'h0145, 16'h8015, 1, 0, 0, 0, 0, 1, 16'h0F05, 12'h545, 0));
        tbl.push_back(mk(16'h0046, 16'h0021, 1, 0, 0, 0, 0, 1, 16'h0F01, 12'h000, 1));
        tbl.push_back(mk(16'h0087, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 12'h487, 0));
        tbl.push_back(mk(16'h00C8, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 12'h4C8, 0));
        tbl.push_back(mk(16'h0109, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 12'h509, 0));
        tbl.push_back(mk(16'h014A, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 12'h54A, 0));
        tbl.push_back(mk(16'h018B, 16'h8016, 2, 0, 0, 1, 0, 1, 16'h0F06, 12'h58B, 0));
        tbl.push_back(mk(16'h018C, 16'h8016, 0, 0, 0, 0, 0, 1, 16'h0F06, 12'h58C, 0));
        tbl.push_back(mk(16'h018D, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 12'h58D, 0));
        tbl.push_back(mk(16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 0, 1, 16'h12FF, 12'hFFF, 0));
        tbl.push_back(mk(16'h018E, 16'h0000, 1, 0, 1, 0, 0, 0, 16'h0000, 12'h58E, 0));
        tbl.push_back(mk(16'h018F, 16'h8016, 1, 0, 0, 0, 0, 1, 16'h0F06, 12'h58F, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            mv = tbl[i];
            m_predict(mv);
            do_req(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a walk, then a late ack that must be ignored.
        bus.req_valid = 1'b1;
        bus.req_vaddr = 16'h0200;
        step();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 10 && !bus.mem_req; k++) step();
        chk("midwalk mem_req up", 32'(bus.mem_req), 32'd1);
        Resetn = 1'b1;
        step();
        Resetn = 1'b0;
        chk("midwalk mem_req", 32'(bus.mem_req), 32'd0);
        chk("midwalk req_ready", 32'(bus.req_ready), 32'd1);
        chk("midwalk rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midwalk mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("midwalk rsp_paddr", 32'(bus.rsp_paddr), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h8001;
        step();
        bus.mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late ack rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("late ack req_ready", 32'(bus.req_ready), 32'd1);
            step();
        end
        m_clear();
        m_hits = 0;
        m_misses = 0;
        mv = mk(16'h0200, 16'h8009, 1, 0, 0, 0, 0, 0, 16'h0, 12'h0, 0);
        m_predict(mv);
        do_req(mv, "post-reset vpn8");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 12; i++)
            pt[i] = {1'($urandom_range(0, 3) != 0), 15'($urandom)};
        for (int i = 0; i < 50; i++) begin
            int vpn = int'($urandom_range(0, 11));
            mv.va     = 16'(vpn * 64 + int'($urandom_range(0, 63)));
            mv.pte    = pt[vpn];
            mv.dly    = int'($urandom_range(0, 3));
            mv.pre_fl = ($urandom_range(0, 9) == 0);
            mv.fll    = ($urandom_range(0, 7) == 0);
            mv.flw    = ($urandom_range(0, 7) == 0);
            mv.hold   = int'($urandom_range(0, 2));
            m_predict(mv);
            do_req(mv, $sformatf("rnd%0d", i));
        end

`ifdef TLB_STATS_EN
        chk("hit_cnt", 32'(hit_cnt), 32'(m_hits));
        chk("miss_cnt", 32'(miss_cnt), 32'(m_misses));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tlb_responder.md
Name: tlb_responder

Overview:
- Address-translation responder on the processor's memory-request interface; the processor is the initiator, this block is the responder.
- Accepts a 16-bit virtual address and returns a physical address from a small fully-associative TLB.
- On a miss, walks a single-level page table through a memory read handshake, fills the TLB and responds; an invalid PTE returns a fault.

Parameters:
- ENTRIES, 4: number of TLB entries (power of 2, 2..16).
- OFF_W, 6: page-offset width in bits; VPN_W = 16-OFF_W.
- PPN_W, 6: physical page number width; PA_W = PPN_W+OFF_W.
- PT_BASE, 16'h0F00: word address of page-table entry 0.

Ports:
- Clock in 1: single clock, all state changes on rising edge.
- Resetn in 1: reset is synchronous and active-high (asserted = 1), sampled on the rising edge of Clock.
- req_valid in 1: processor presents a translation request.
- req_ready out 1: block can accept; high only in IDLE.
- req_vaddr in 16: virtual address, captured on accept.
- rsp_valid out 1: response available; held until consumed.
- rsp_ready in 1: processor consumes the response.
- rsp_paddr out PA_W: translated physical address.
- rsp_fault out 1: page fault, meaning the PTE valid bit was 0.
- flush in 1: invalidate all TLB entries.
- mem_req out 1: page-table read request.
- mem_addr out 16: PT_BASE + VPN, zero-extended, modulo 2^16.
- mem_ack in 1: memory has returned data.
- mem_rdata in 16: PTE; bit 15 = valid, bits [PPN_W-1:0] = PPN; all other bits ignored.

Behaviour:
- Reset (Resetn=1 at edge):
  - All entry valid bits cleared, rr pointer = 0, state = IDLE.
  - rsp_valid=0, rsp_paddr=0, rsp_fault=0, mem_req=0, mem_addr=0.
  - req_ready=1 from the first cycle after reset deassertion.
  - Reset mid-walk or mid-response aborts with no fill; any late mem_ack is ignored.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, capture vaddr and go to LOOKUP.
  - LOOKUP: compare VPN against all valid entries. Hit goes to RESP with paddr = {PPN, offset}. Miss goes to WALK.
  - WALK: mem_req=1 and mem_addr held stable until mem_ack is sampled high. At that edge, register the PTE and go to RESP.
    - PTE valid: fill one entry and set paddr = {PTE PPN, offset}, fault=0.
    - PTE invalid: no fill, paddr=0, fault=1.
  - RESP: rsp_valid=1; paddr and fault held stable. On rsp_ready, go to IDLE.
- Latency:
  - Hit: rsp_valid asserts 2 edges after the accept edge.
  - Miss: rsp_valid asserts on the edge that samples mem_ack.
  - A new accept is possible on the edge after rsp_ready is sampled; there is no back-to-back overlap.
- Replacement:
  - Victim is the lowest-index invalid entry if one exists.
  - Otherwise the victim is entry[rr]; rr then increments modulo ENTRIES.
  - rr is unchanged when an invalid slot is used.
- Duplicate entries for the same VPN never occur, because a fill only follows a miss.
- Flush:
  - Clears all valid bits at the edge; rr is reset to 0.
  - Flush during LOOKUP takes effect at that edge; a hit in that cycle still responds.
  - Flush asserted at any edge during WALK suppresses the pending fill; the response is still delivered with the PTE translation.
  - Flush and fill on the same edge: flush wins and the entry stays invalid.
- mem_ack outside WALK is ignored. req_valid outside IDLE is ignored because req_ready=0.

Optional Feature:
- Macro TLB_STATS_EN.
- Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - hit_cnt increments on each LOOKUP hit; miss_cnt increments on each LOOKUP miss.
  - Both wrap at 2^16 and reset to 0 on Resetn; they are not cleared by flush.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan (defaults: OFF_W=6, PT_BASE=16'h0F00):
- Cold miss: vaddr 16'h0085, mem_ack 3 cycles after mem_req with mem_rdata 16'h8003 -> mem_addr=16'h0F02; rsp_paddr=12'h0C5, rsp_fault=0.
- Hit after fill: vaddr 16'h0087 -> no mem_req; rsp_valid 2 edges after accept; rsp_paddr=12'h0C7.
- Fault: vaddr 16'h0100, mem_rdata 16'h0003 -> rsp_fault=1, rsp_paddr=0; repeating 16'h0100 misses again (mem_addr=16'h0F04).
- Replacement: fill VPNs 1,2,3,4, then VPN 5 -> VPN 1 evicted (rr 0->1); re-request VPN 1 -> miss; VPN 2..5 -> hits.
- Flush and backpressure:
  - Flush after fills -> the next request for a filled VPN misses.
  - Flush during WALK -> response delivered, but the same VPN misses again.
  - Hold rsp_ready=0 for 4 cycles -> rsp_valid, rsp_paddr and rsp_fault stable; req_ready=0 throughout.
- Reset mid-walk: Resetn=1 while mem_req=1 -> mem_req=0 and req_ready=1 after the edge; a late mem_ack causes no fill and no rsp_valid.
